// File: rtl/serial_master_port.sv
// Serial bus master: accepts one client transaction at a time, arbitrates for the
// bus, shifts the address and write data out LSB first and collects read data.
module serial_master_port #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              breq,
    input  logic              bgrant,
    output logic              bus_valid,
    output logic              bus_tx,
    output logic              bus_mode,
    input  logic              slave_ready,
    input  logic              bus_rx,
    input  logic              bus_rx_valid
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_ADDR     = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_WDATA    = 3'd4,
        S_RDATA    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [TMR_W-1:0]  r_timer;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_shift;
    logic              r_req_ready;
    logic              r_breq;
    logic              r_bus_valid;
    logic              r_bus_tx;
    logic              r_bus_mode;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              w_on_bus;

    assign w_on_bus = (r_state == S_ADDR) || (r_state == S_WAIT_ACK) ||
                      (r_state == S_WDATA) || (r_state == S_RDATA);

    // Transaction FSM with all client and bus outputs registered alongside the state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_shift     <= '0;
            r_req_ready <= 1'b1;
            r_breq      <= 1'b0;
            r_bus_valid <= 1'b0;
            r_bus_tx    <= 1'b0;
            r_bus_mode  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_on_bus && !bgrant) begin
                // Grant loss aborts at once; rsp_rdata only changes on a clean read.
                r_state     <= S_DONE;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b1;
                r_breq      <= 1'b0;
                r_bus_valid <= 1'b0;
                r_bus_tx    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (req_valid) begin
                            r_state     <= S_REQ;
                            r_addr      <= req_addr;
                            r_wdata     <= req_wdata;
                            r_bus_mode  <= req_rw;
                            r_req_ready <= 1'b0;
                            r_breq      <= 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (bgrant) begin
                            r_state     <= S_ADDR;
                            r_cnt       <= '0;
                            r_bus_valid <= 1'b1;
                            r_bus_tx    <= r_addr[0];
                            r_addr      <= {1'b0, r_addr[ADDR_W-1:1]};
                        end
                    end
                    S_ADDR: begin
                        if (r_cnt == ADDR_LAST) begin
                            r_state     <= S_WAIT_ACK;
                            r_timer     <= '0;
                            r_bus_valid <= 1'b0;
                            r_bus_tx    <= 1'b0;
                        end else begin
                            r_cnt    <= r_cnt + CNT_W'(1);
                            r_bus_tx <= r_addr[0];
                            r_addr   <= {1'b0, r_addr[ADDR_W-1:1]};
                        end
                    end
                    S_WAIT_ACK: begin
                        if (slave_ready) begin
                            r_cnt <= '0;
                            if (r_bus_mode) begin
                                r_state     <= S_WDATA;
                                r_bus_valid <= 1'b1;
                                r_bus_tx    <= r_wdata[0];
                                r_wdata     <= {1'b0, r_wdata[DATA_W-1:1]};
                            end else begin
                                r_state <= S_RDATA;
                                r_timer <= '0;
                                r_shift <= '0;
                            end
                        end else if (r_timer == TMR_LAST) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_breq      <= 1'b0;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    S_WDATA: begin
                        if (r_cnt == DATA_LAST) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_breq      <= 1'b0;
                            r_bus_valid <= 1'b0;
                            r_bus_tx    <= 1'b0;
                        end else begin
                            r_cnt    <= r_cnt + CNT_W'(1);
                            r_bus_tx <= r_wdata[0];
                            r_wdata  <= {1'b0, r_wdata[DATA_W-1:1]};
                        end
                    end
                    S_RDATA: begin
                        if (bus_rx_valid) begin
                            // Shift in from the top so the first sample lands in bit 0.
                            r_shift <= {bus_rx, r_shift[DATA_W-1:1]};
                            r_timer <= '0;
                            if (r_cnt == DATA_LAST) begin
                                r_state     <= S_DONE;
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 1'b0;
                                r_rsp_rdata <= {bus_rx, r_shift[DATA_W-1:1]};
                                r_breq      <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end else if (r_timer == TMR_LAST) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_breq      <= 1'b0;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    S_DONE: begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_cnt       <= '0;
                        r_timer     <= '0;
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_breq      <= 1'b0;
                        r_bus_valid <= 1'b0;
                        r_bus_tx    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign breq      = r_breq;
    assign bus_valid = r_bus_valid;
    assign bus_tx    = r_bus_tx;
    assign bus_mode  = r_bus_mode;

endmodule

// File: doc/serial_master_port.md
SERIAL_MASTER_PORT -- requirements
Module: serial_master_port

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the serial address width in bits.
REQ-002 Parameter DATA_W, default 8, SHALL set the data width in bits.
REQ-003 Parameter TIMEOUT, default 16, SHALL set the number of slave-wait cycles before abort.
REQ-004 clk  in  1  SHALL be the clock; all state updates on the rising edge.
REQ-005 rstn  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 req_valid  in  1  SHALL request a client transaction.
REQ-007 req_rw  in  1  SHALL select the direction: 1 = write, 0 = read.
REQ-008 req_addr  in  ADDR_W  SHALL carry the target address.
REQ-009 req_wdata  in  DATA_W  SHALL carry the write data.
REQ-010 req_ready  out  1  SHALL indicate the port is idle and accepting requests.
REQ-011 rsp_valid  out  1  SHALL be a one-cycle completion pulse.
REQ-012 rsp_rdata  out  DATA_W  SHALL carry the read result.
REQ-013 rsp_err  out  1  SHALL flag timeout or grant loss, valid with rsp_valid.
REQ-014 breq  out  1  SHALL request the bus from the arbiter.
REQ-015 bgrant  in  1  SHALL be the arbiter grant.
REQ-016 bus_valid  out  1  SHALL qualify bus_tx bits.
REQ-017 bus_tx  out  1  SHALL carry the master-to-slave serial bit.
REQ-018 bus_mode  out  1  SHALL carry the latched rw for the whole transaction.
REQ-019 slave_ready  in  1  SHALL signal that the addressed slave accepts the transaction.
REQ-020 bus_rx  in  1  SHALL carry the slave-to-master serial bit.
REQ-021 bus_rx_valid  in  1  SHALL qualify bus_rx.

Function
REQ-022 The FSM SHALL have states IDLE, REQ, ADDR, WAIT_ACK, WDATA, RDATA and DONE; all outputs SHALL be registered or decoded from state only.
REQ-023 In IDLE: req_ready=1; when req_valid=1, latch addr/wdata/rw, go to REQ; req_ready=0 in all other states.
REQ-024 In REQ: breq=1; on bgrant=1 go to ADDR with bit counter 0; otherwise wait indefinitely.
REQ-025 In ADDR: bus_valid=1, bus_tx=addr[cnt], LSB first, for exactly ADDR_W cycles; then go to WAIT_ACK with timer 0.
REQ-026 In WAIT_ACK: bus_valid=0; slave_ready=1 goes to WDATA (write) or RDATA (read); after TIMEOUT cycles without slave_ready, go to DONE with err=1.
REQ-027 In WDATA: bus_valid=1, bus_tx=wdata[cnt], LSB first, for exactly DATA_W cycles; then go to DONE.
REQ-028 In RDATA: shift bus_rx into rdata LSB first on each bus_rx_valid=1 cycle; after DATA_W samples go to DONE; the timer resets on each sample; TIMEOUT idle cycles set err=1 and go to DONE.
REQ-029 breq SHALL be 1 in REQ through RDATA/WDATA and 0 in DONE and IDLE.
REQ-030 bgrant=0 in ADDR, WAIT_ACK, WDATA or RDATA SHALL abort: next state DONE, err=1, bus_valid=0 the next cycle.
REQ-031 In DONE: rsp_valid=1 for one cycle, rsp_rdata holds the shifted value (write: unchanged), rsp_err reports; then go to IDLE.
REQ-032 rsp_rdata and rsp_err SHALL hold until the next DONE.
REQ-033 A req_valid in the same cycle as DONE SHALL be ignored; acceptance occurs only in IDLE.
REQ-034 Latency at defaults with bgrant and slave_ready already high: acceptance cycle 0, rsp_valid at cycle 23 (write).

Reset
REQ-035 rstn=0 SHALL immediately force IDLE, counters 0, req_ready=1, and breq, bus_valid, bus_tx, bus_mode, rsp_valid, rsp_err and rsp_rdata to 0, including mid-transaction.

Verification
REQ-036 Write addr=0x5A3, data=0xC6, grant and ready held high -> bus_tx LSB-first 0x5A3 over 12 cycles, then 0xC6 over 8; rsp_valid at cycle 23, err=0.
REQ-037 Read with the slave returning 0x81 on gapped bus_rx_valid -> rsp_rdata=0x81, err=0, one-cycle rsp_valid.
REQ-038 slave_ready never asserted -> 16 WAIT_ACK cycles, then rsp_valid with err=1 and breq=0.
REQ-039 bgrant held 0 for 50 cycles, then 1 -> breq high throughout, no bus_valid until grant, normal completion.
REQ-040 bgrant dropped at ADDR bit 5 -> bus_valid=0 next cycle, rsp_valid with err=1, then return to IDLE.
REQ-041 rstn pulsed during WDATA -> all outputs at reset values asynchronously, req_ready=1, next request completes normally.
